instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
// - Parametrised instruction memory for the pipelined RV32I core, fetch-stage side.
// - Memory is cleared to FILL_WORD after reset and loaded through a word-serial loader port.
// - Programs change without re-synthesis.
// - Fetch is a registered read (1-cycle latency) with stall hold and misalignment flag.
// PARAMETERS
// - WIDTH      32            instruction word width, bits
// - DEPTH      256           number of words, power of 2, >= 4
// - FILL_WORD  32'h00000013  value written by CLEAR sweep (addi x0,x0,0 = NOP)
// - AW         $clog2(DEPTH) word-index width (localparam, not overridable)
// PORTS
// - clk          in   1       clock, rising edge
// - arst         in   1       asynchronous reset, active-high
// - fetch_req    in   1       fetch request from IF stage
// - fetch_addr   in   AW+2    byte address (PC low bits)
// - stall        in   1       hold fetch output registers
// - instr        out  WIDTH   fetched instruction
// - instr_valid  out  1       instr holds a valid fetch result
// - misalign     out  1       registered: fetch_addr[1:0] != 0 on accepted fetch
// - ld_start     in   1       pulse: enter LOAD mode
// - ld_valid     in   1       loader word valid
// - ld_addr      in   AW      loader word index
// - ld_data      in   WIDTH   loader word
// - ld_last      in   1       marks final loader word
// - ld_ready     out  1       loader may transfer this cycle
// - busy         out  1       1 in CLEAR or LOAD; IF stage must not rely on instr
// BEHAVIOUR
// - Reset values (async, while arst=1):
//   - state=CLEAR, sweep index=0
//   - instr=FILL_WORD, instr_valid=0, misalign=0, ld_ready=0, busy=1
// - FSM CLEAR:
//   - Writes FILL_WORD to word[idx] each cycle, idx 0..DEPTH-1.
//   - After writing DEPTH-1 -> RUN; takes exactly DEPTH cycles after arst deassert.
//   - ld_start and fetch_req are ignored.
// - FSM RUN:
//   - ld_start=1 -> LOAD on next edge; a fetch in the same cycle is still served.
// - FSM LOAD:
//   - ld_ready=1.
//   - ld_valid&ld_ready writes ld_data to word[ld_addr] at the edge.
//   - ld_valid&ld_last -> RUN after that write.
//   - ld_start while in LOAD is ignored.
//   - Repeated ld_addr: last write wins.
// - Fetch (RUN only):
//   - Word index = fetch_addr[AW+1:2].
//   - fetch_req & !stall at edge N -> instr=word[idx], instr_valid=1 at edge N+1.
//   - misalign=|fetch_addr[1:0]; when misaligned, instr=FILL_WORD and instr_valid=1.
//   - fetch_req=0 & !stall -> instr_valid=0, instr unchanged.
//   - stall=1 -> instr, instr_valid and misalign hold their values; stall overrides fetch_req.
//   - In CLEAR or LOAD: instr_valid=0, instr=FILL_WORD.
// - Read-during-write: the memory is only written in CLEAR/LOAD, when fetch is disabled, so no collision can occur.
// - arst mid-LOAD or mid-CLEAR: LOAD is aborted, the sweep restarts at 0 and memory contents are lost.
// - Word address wraps naturally; no out-of-range byte addresses exist (AW+2 bits).
// - Storage is an array inferred as RAM, one write port and one registered read port.
// - Reset does not touch the array; only the CLEAR sweep initialises it.
// TESTING
// - Reset, then idle DEPTH cycles:
//   - busy=1 for exactly 256 cycles, then 0.
//   - Fetch at 0x3FC -> instr=32'h00000013, instr_valid=1.
// - Load 17-word program (word0=32'h00200613 .. word16=32'hfc1ff7ef, ld_last on word16):
//   - Fetch 0x000 -> 32'h00200613 one cycle later.
//   - Fetch 0x040 -> 32'hfc1ff7ef one cycle later.
// - Back-to-back fetches 0x00,0x04,0x08 with stall=1 on the second:
//   - The second cycle's output repeats the first result; the sequence resumes after stall drops.
// - Fetch at 0x006:
//   - misalign=1, instr=32'h00000013, instr_valid=1.
//   - Next aligned fetch clears misalign.
// - ld_start, write 2 words, then arst pulse:
//   - busy=1, CLEAR restarts.
//   - Loaded words read 32'h00000013 after the sweep.
// - ld_valid held with ld_ready=0 (during CLEAR):
//   - No write occurs; word still FILL_WORD after CLEAR.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Fetch-side instruction memory for the pipelined RV32I core: cleared to FILL_WORD after
// reset, loaded word-serially through the loader port, read with one registered fetch port.
module instr_mem_loader #(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 256,
  parameter logic [WIDTH-1:0] FILL_WORD = 32'h00000013,
  localparam int             AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             fetch_req,
  input  logic [AW+1:0]    fetch_addr,
  input  logic             stall,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic             misalign,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [AW-1:0]    idx_r;
  logic             we_s;
  logic [AW-1:0]    waddr_s;
  logic [WIDTH-1:0] wdata_s;

  logic [WIDTH-1:0] mem_r [DEPTH];

  logic [WIDTH-1:0] instr_r, instr_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             mis_r, mis_nxt_s;

  logic [AW-1:0]    fetch_idx_s;
  logic             fetch_mis_s;
  logic [WIDTH-1:0] rd_word_s;

  assign fetch_idx_s = fetch_addr[AW+1:2];
  assign fetch_mis_s = |fetch_addr[1:0];
  assign rd_word_s   = mem_r[fetch_idx_s];

  // State register and clear-sweep index
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r <= ST_CLEAR;
      idx_r   <= {AW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_CLEAR) begin
        idx_r <= idx_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        idx_r <= {AW{1'b0}};
      end
    end
  end

  // Next-state and memory write-port selection
  always_comb begin
    state_nxt_s = state_r;
    we_s        = 1'b0;
    waddr_s     = {AW{1'b0}};
    wdata_s     = FILL_WORD;
    case (state_r)
      ST_CLEAR: begin
        we_s    = 1'b1;
        waddr_s = idx_r;
        if (idx_r == {AW{1'b1}}) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN: begin
        if (ld_start) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          we_s    = 1'b1;
          waddr_s = ld_addr;
          wdata_s = ld_data;
          if (ld_last) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
      end
    endcase
  end

  // Single write port; the array itself is never reset
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  // Fetch output next-value: stall holds, misaligned fetches return the fill word
  always_comb begin
    instr_nxt_s = instr_r;
    valid_nxt_s = valid_r;
    mis_nxt_s   = mis_r;
    if (state_r != ST_RUN) begin
      instr_nxt_s = FILL_WORD;
      valid_nxt_s = 1'b0;
      mis_nxt_s   = 1'b0;
    end else if (stall) begin
      instr_nxt_s = instr_r;
      valid_nxt_s = valid_r;
      mis_nxt_s   = mis_r;
    end else if (fetch_req) begin
      valid_nxt_s = 1'b1;
      mis_nxt_s   = fetch_mis_s;
      if (fetch_mis_s) begin
        instr_nxt_s = FILL_WORD;
      end else begin
        instr_nxt_s = rd_word_s;
      end
    end else begin
      valid_nxt_s = 1'b0;
    end
  end

  // Fetch output registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      instr_r <= FILL_WORD;
      valid_r <= 1'b0;
      mis_r   <= 1'b0;
    end else begin
      instr_r <= instr_nxt_s;
      valid_r <= valid_nxt_s;
      mis_r   <= mis_nxt_s;
    end
  end

  assign instr       = instr_r;
  assign instr_valid = valid_r;
  assign misalign    = mis_r;
  assign ld_ready    = (state_r == ST_LOAD);
  assign busy        = (state_r != ST_RUN);

endmodule
